// File: rtl/cpu_pkg.sv
// Shared fetch/decode types and instruction field positions.
// Instruction layout: opcode[15:9] dr[8:6] sa[5:3] sb[2:0].
package cpu_pkg;

   localparam int ADDR_W  = 8;
   localparam int INSTR_W = 16;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 9;
   localparam int DR_LSB  = 6;
   localparam int SA_LSB  = 3;
   localparam int SB_LSB  = 0;

   typedef enum logic [1:0] {
      IFU_IDLE,
      IFU_REQ,
      IFU_DONE
   } ifu_state_e;

   // 6-bit two's complement offset widened to a PC-sized value
   function automatic logic [7:0] sext6(input logic [5:0] v);
      return {{2{v[5]}}, v};
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read port: req/addr out, ack/rdata back.
// master = fetch unit, slave = instruction memory.
interface instr_fetch_unit_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 16
);

   logic               mem_req;
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_ack;
   logic [INSTR_W-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata
   );

endinterface

// File: rtl/instr_decode.sv
// Combinational IR field split and offset sign extension.
// Shared with the control unit, so kept free of state.
module instr_decode (
   input  logic [15:0] ir,
   output logic [6:0]  opcode,
   output logic [2:0]  dr,
   output logic [2:0]  sa,
   output logic [2:0]  sb,
   output logic [7:0]  extend
);

   import cpu_pkg::*;

   assign opcode = ir[OPC_MSB:OPC_LSB];
   assign dr     = ir[DR_LSB +: 3];
   assign sa     = ir[SA_LSB +: 3];
   assign sb     = ir[SB_LSB +: 3];
   assign extend = sext6({dr, sb});

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC -> memory req/ack -> IR, decode, PC increment.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
   parameter int ADDR_W      = 8,
   parameter int INSTR_W     = 16,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_il,
   input  logic                i_flush,
   input  logic [ADDR_W-1:0]   i_pc,
   instr_fetch_unit_if.master  mem,
   output logic [INSTR_W-1:0]  o_ir,
   output logic [6:0]          o_opcode,
   output logic [2:0]          o_dr,
   output logic [2:0]          o_sa,
   output logic [2:0]          o_sb,
   output logic [7:0]          o_extend,
   output logic                o_ir_valid,
   output logic                o_pi,
   output logic                o_busy,
   output logic [15:0]         o_fetch_cnt,
   output logic                o_fetch_err
);

   import cpu_pkg::*;

   ifu_state_e         state;
   logic [ADDR_W-1:0]  addr_q;
   logic [INSTR_W-1:0] ir_q;
   logic               req_q;
   logic               vld_q;
   logic               busy_q;
   logic [15:0]        cnt_q;

`ifdef FETCH_TIMEOUT_EN
   logic [7:0] wait_q;
   logic       err_q;
   logic       tmo;

   assign tmo = (wait_q == 8'(TIMEOUT_CYC - 1));
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state  <= IFU_IDLE;
         addr_q <= '0;
         ir_q   <= '0;
         req_q  <= 1'b0;
         vld_q  <= 1'b0;
         busy_q <= 1'b0;
         cnt_q  <= '0;
`ifdef FETCH_TIMEOUT_EN
         wait_q <= '0;
         err_q  <= 1'b0;
`endif
      end else begin
         vld_q <= 1'b0;
         unique case (state)
            IFU_IDLE: begin
               // flush beats a same-cycle load request
               if (i_il && !i_flush) begin
                  addr_q <= i_pc;
                  req_q  <= 1'b1;
                  busy_q <= 1'b1;
                  state  <= IFU_REQ;
`ifdef FETCH_TIMEOUT_EN
                  wait_q <= '0;
`endif
               end
            end
            IFU_REQ: begin
               if (i_flush) begin
                  req_q  <= 1'b0;
                  busy_q <= 1'b0;
                  state  <= IFU_IDLE;
               end else if (mem.mem_ack) begin
                  ir_q  <= mem.mem_rdata;
                  req_q <= 1'b0;
                  vld_q <= 1'b1;
                  if (cnt_q != 16'hFFFF)
                     cnt_q <= cnt_q + 16'd1;
                  state <= IFU_DONE;
               end
`ifdef FETCH_TIMEOUT_EN
               else if (tmo) begin
                  req_q  <= 1'b0;
                  busy_q <= 1'b0;
                  err_q  <= 1'b1;
                  state  <= IFU_IDLE;
               end else begin
                  wait_q <= wait_q + 8'd1;
               end
`endif
            end
            IFU_DONE: begin
               busy_q <= 1'b0;
               state  <= IFU_IDLE;
            end
            default: begin
               req_q  <= 1'b0;
               busy_q <= 1'b0;
               state  <= IFU_IDLE;
            end
         endcase
      end
   end

   assign mem.mem_req  = req_q;
   assign mem.mem_addr = addr_q;

   assign o_ir        = ir_q;
   assign o_ir_valid  = vld_q;
   assign o_pi        = vld_q;
   assign o_busy      = busy_q;
   assign o_fetch_cnt = cnt_q;

`ifdef FETCH_TIMEOUT_EN
   assign o_fetch_err = err_q;
`else
   logic unused_tmo;
   assign unused_tmo  = ^TIMEOUT_CYC;
   assign o_fetch_err = 1'b0;
`endif

   instr_decode u_dec (
      .ir     (ir_q),
      .opcode (o_opcode),
      .dr     (o_dr),
      .sa     (o_sa),
      .sb     (o_sb),
      .extend (o_extend)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit (watchdog checks when
// FETCH_TIMEOUT_EN is defined, with TIMEOUT_CYC=4).
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst;
   logic        il;
   logic        flush;
   logic [7:0]  pc;
   logic [15:0] ir;
   logic [6:0]  opcode;
   logic [2:0]  dr;
   logic [2:0]  sa;
   logic [2:0]  sb;
   logic [7:0]  extend;
   logic        ir_valid;
   logic        pi;
   logic        busy;
   logic [15:0] fetch_cnt;
   logic        fetch_err;

   instr_fetch_unit_if #(.ADDR_W(8), .INSTR_W(16)) mem ();

   instr_fetch_unit #(
      .ADDR_W      (8),
      .INSTR_W     (16),
      .TIMEOUT_CYC (4)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_il        (il),
      .i_flush     (flush),
      .i_pc        (pc),
      .mem         (mem),
      .o_ir        (ir),
      .o_opcode    (opcode),
      .o_dr        (dr),
      .o_sa        (sa),
      .o_sb        (sb),
      .o_extend    (extend),
      .o_ir_valid  (ir_valid),
      .o_pi        (pi),
      .o_busy      (busy),
      .o_fetch_cnt (fetch_cnt),
      .o_fetch_err (fetch_err)
   );

   typedef struct {
      logic [15:0] ir;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sbq[$];
   int          n_chk;
   int          n_pass;
   int          n_vld;
   int          n_fetch;
   logic [15:0] exp_cnt;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
   endtask

   function automatic logic [7:0] ext_model(input logic [15:0] w);
      int v;
      v = int'(w[8:6]) * 8 + int'(w[2:0]);
      if (v > 31) v = v - 64;
      return v[7:0];
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "bench timeout");
   end

   // pop and compare whenever the DUT announces a new IR
   always @(negedge clk) begin
      if (ir_valid) begin
         exp_t e;
         n_vld++;
         if (sbq.size() == 0) begin
            chk("unexpected_valid", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("ir", ir, e.ir);
            chk("opcode", opcode, e.ir[15:9]);
            chk("dr", dr, e.ir[8:6]);
            chk("sa", sa, e.ir[5:3]);
            chk("sb", sb, e.ir[2:0]);
            chk("extend", extend, ext_model(e.ir));
            chk("pi", pi, 1'b1);
            chk("cnt", fetch_cnt, e.cnt);
         end
      end
   end

   task automatic fetch(input logic [7:0] a,
                        input logic [15:0] rd,
                        input int dly,
                        input bit poke);
      @(negedge clk);
      chk("vld_clear", ir_valid, 1'b0);
      chk("pi_clear", pi, 1'b0);
      il = 1'b1;
      pc = a;
      @(negedge clk);
      il = 1'b0;
      chk("req", mem.mem_req, 1'b1);
      chk("addr", mem.mem_addr, a);
      for (int i = 0; i < dly; i++) begin
         if (poke && i == 1) begin
            il = 1'b1;
            pc = 8'h20;
         end else begin
            il = 1'b0;
         end
         @(negedge clk);
         chk("req_hold", mem.mem_req, 1'b1);
         chk("addr_hold", mem.mem_addr, a);
      end
      il = 1'b0;
      mem.mem_ack = 1'b1;
      mem.mem_rdata = rd;
      exp_cnt = exp_cnt + 16'd1;
      n_fetch++;
      sbq.push_back('{ir: rd, cnt: exp_cnt});
      @(negedge clk);
      mem.mem_ack = 1'b0;
      mem.mem_rdata = 16'h0000;
      chk("req_drop", mem.mem_req, 1'b0);
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      n_vld = 0;
      n_fetch = 0;
      exp_cnt = 16'd0;
      rst = 1'b1;
      il = 1'b0;
      flush = 1'b0;
      pc = 8'h00;
      mem.mem_ack = 1'b0;
      mem.mem_rdata = 16'h0000;
      repeat (2) @(negedge clk);
      chk("rst_ir", ir, 16'h0000);
      chk("rst_req", mem.mem_req, 1'b0);
      chk("rst_addr", mem.mem_addr, 8'h00);
      chk("rst_vld", ir_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_cnt", fetch_cnt, 16'h0000);
      chk("rst_err", fetch_err, 1'b0);
      rst = 1'b0;

      fetch(8'h0A, 16'h8A4B, 0, 1'b0);
      fetch(8'h10, 16'h0104, 0, 1'b0);
      chk("neg_extend", extend, 8'hE4);
      fetch(8'h0A, 16'h1234, 5, 1'b0);
      fetch(8'h0A, 16'h5A5A, 5, 1'b1);
      @(negedge clk);
      chk("one_fetch_busy", busy, 1'b0);
      chk("one_fetch_cnt", fetch_cnt, 16'd4);

      // flush collides with ack in REQ
      il = 1'b1;
      pc = 8'h33;
      @(negedge clk);
      il = 1'b0;
      chk("fl_req", mem.mem_req, 1'b1);
      flush = 1'b1;
      mem.mem_ack = 1'b1;
      mem.mem_rdata = 16'hFFFF;
      @(negedge clk);
      flush = 1'b0;
      mem.mem_ack = 1'b0;
      chk("fl_busy", busy, 1'b0);
      chk("fl_req_low", mem.mem_req, 1'b0);
      chk("fl_ir", ir, 16'h5A5A);
      chk("fl_vld", ir_valid, 1'b0);
      chk("fl_cnt", fetch_cnt, 16'd4);

      // flush with load in IDLE, then stray ack in IDLE
      il = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      il = 1'b0;
      flush = 1'b0;
      chk("fl_il_busy", busy, 1'b0);
      chk("fl_il_req", mem.mem_req, 1'b0);
      mem.mem_ack = 1'b1;
      mem.mem_rdata = 16'h5555;
      @(negedge clk);
      mem.mem_ack = 1'b0;
      chk("idle_ack_ir", ir, 16'h5A5A);
      chk("idle_ack_busy", busy, 1'b0);

      // asynchronous reset in the middle of REQ
      il = 1'b1;
      pc = 8'h44;
      @(negedge clk);
      il = 1'b0;
      chk("ar_req", mem.mem_req, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("ar_req_low", mem.mem_req, 1'b0);
      chk("ar_ir", ir, 16'h0000);
      chk("ar_cnt", fetch_cnt, 16'h0000);
      chk("ar_busy", busy, 1'b0);
      chk("ar_addr", mem.mem_addr, 8'h00);
      exp_cnt = 16'd0;
      @(negedge clk);
      rst = 1'b0;
      mem.mem_ack = 1'b1;
      mem.mem_rdata = 16'hABCD;
      @(negedge clk);
      mem.mem_ack = 1'b0;
      chk("stale_ir", ir, 16'h0000);
      chk("stale_busy", busy, 1'b0);
      chk("stale_vld", ir_valid, 1'b0);

      fetch(8'h05, 16'h7FC7, 0, 1'b0);

`ifdef FETCH_TIMEOUT_EN
      @(negedge clk);
      il = 1'b1;
      pc = 8'h66;
      @(negedge clk);
      il = 1'b0;
      chk("to_busy0", busy, 1'b1);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         chk("to_busy", busy, 1'b1);
      end
      @(negedge clk);
      chk("to_idle", busy, 1'b0);
      chk("to_err", fetch_err, 1'b1);
      chk("to_ir", ir, 16'h7FC7);
      fetch(8'h07, 16'h0E38, 0, 1'b0);
      chk("to_sticky", fetch_err, 1'b1);
`else
      chk("err_tied", fetch_err, 1'b0);
`endif

      repeat (2) @(negedge clk);
      chk("sb_empty", sbq.size(), 0);
      chk("pulses", n_vld, n_fetch);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
